// File: rtl/key_pkg.sv
// Shared definitions for the key register file slice.
//   - default key/word widths
//   - loader FSM state encodings (legacy-compatible constants)
//   - half-select constants
package key_pkg;

  localparam int KEY_WIDTH_DEF  = 512;
  localparam int WORD_WIDTH_DEF = 32;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] LOAD   = 2'b01;
  localparam logic [1:0] COMMIT = 2'b10;

  localparam logic SEL_LOWER = 1'b0;
  localparam logic SEL_UPPER = 1'b1;

endpackage

// File: rtl/key_word_loader.sv
// Host-side word loader: collects NUM_WORDS words of WORD_WIDTH bits into a
// staging register, then presents the full half for a one-cycle commit.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   key_clear      zeroise staging, force IDLE
//   load_start     begin (or restart) a load of half load_sel
//   load_sel       target half, latched on load_start
//   load_word      key word, word 0 lands in the LSBs
//   load_valid     load_word is valid
//   load_ready     a word is accepted this cycle (LOAD state)
//   commit_stb     high for the single COMMIT cycle
//   commit_sel     half being committed
//   commit_data    staged key half
module key_word_loader
  import key_pkg::*;
#(
  parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_clear,
  input  logic                  load_start,
  input  logic                  load_sel,
  input  logic [WORD_WIDTH-1:0] load_word,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  commit_stb,
  output logic                  commit_sel,
  output logic [KEY_WIDTH-1:0]  commit_data
);

  localparam int NUM_WORDS = KEY_WIDTH / WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS) + 1;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic [KEY_WIDTH-1:0] stg_q, stg_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    stg_d   = stg_q;
    if (key_clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      stg_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            sel_d   = load_sel;
            cnt_d   = '0;
            stg_d   = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          // A restart takes precedence over a word presented in the same cycle.
          if (load_start) begin
            sel_d = load_sel;
            cnt_d = '0;
            stg_d = '0;
          end else if (load_valid) begin
            for (int unsigned k = 0; k < NUM_WORDS; k++) begin
              if (cnt_q == CNT_W'(k)) stg_d[k*WORD_WIDTH +: WORD_WIDTH] = load_word;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_WORDS - 1)) state_d = COMMIT;
          end
        end
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= SEL_LOWER;
      stg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      stg_q   <= stg_d;
    end
  end

  assign load_ready  = (state_q == LOAD);
  assign commit_stb  = (state_q == COMMIT);
  assign commit_sel  = sel_q;
  assign commit_data = stg_q;

endmodule

// File: rtl/key_reg_file.sv
// 1024-bit key store as two KEY_WIDTH halves, responder to the XOR engine's
// register-file interface, with a word loader and zeroisation.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reg_file_rw         1 = direct write of reg_file_data_in, 0 = read
//   reg_file_sel        half select (0 lower, 1 upper)
//   reg_file_data_in    direct write data
//   reg_file_data_out   registered read data (1-cycle latency)
//   load_*              word loader handshake and status pulses
//   key_clear           zeroise halves, staging, valid flags and read data
//   key_valid           per-half valid flags
module key_reg_file
  import key_pkg::*;
#(
  parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_file_rw,
  input  logic                  reg_file_sel,
  input  logic [KEY_WIDTH-1:0]  reg_file_data_in,
  output logic [KEY_WIDTH-1:0]  reg_file_data_out,
  input  logic                  load_start,
  input  logic                  load_sel,
  input  logic [WORD_WIDTH-1:0] load_word,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  load_err,
  input  logic                  key_clear,
  output logic [1:0]            key_valid
);

  logic                 commit_stb;
  logic                 commit_sel;
  logic [KEY_WIDTH-1:0] commit_data;

  logic [KEY_WIDTH-1:0] half_q [2];
  logic [KEY_WIDTH-1:0] half_d [2];
  logic [1:0]           valid_q, valid_d;
  logic [KEY_WIDTH-1:0] rd_q, rd_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  key_word_loader #(
    .KEY_WIDTH  (KEY_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_loader (
    .clk         (clk),
    .rst         (rst),
    .key_clear   (key_clear),
    .load_start  (load_start),
    .load_sel    (load_sel),
    .load_word   (load_word),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .commit_stb  (commit_stb),
    .commit_sel  (commit_sel),
    .commit_data (commit_data)
  );

  always_comb begin
    half_d  = half_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (key_clear) begin
      half_d[0] = '0;
      half_d[1] = '0;
      valid_d   = '0;
      rd_d      = '0;
    end else begin
      // Reads sample the pre-update contents, so same-cycle writes show up next read.
      if (!reg_file_rw) rd_d = half_q[reg_file_sel];
      if (commit_stb) begin
        if (reg_file_rw && (reg_file_sel == commit_sel)) begin
          err_d = 1'b1;
        end else begin
          half_d[commit_sel]  = commit_data;
          valid_d[commit_sel] = 1'b1;
          done_d              = 1'b1;
        end
      end
      if (reg_file_rw) begin
        half_d[reg_file_sel]  = reg_file_data_in;
        valid_d[reg_file_sel] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_q[0] <= '0;
      half_q[1] <= '0;
      valid_q   <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      half_q[0] <= half_d[0];
      half_q[1] <= half_d[1];
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign reg_file_data_out = rd_q;
  assign key_valid         = valid_q;
  assign load_done         = done_q;
  assign load_err          = err_q;

endmodule
